// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared FSM state encoding and word lengths for the SPI responder
package spi_slave_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam int WORD8 = 8;
  localparam int WORD32 = 32;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses evaluated on enable cycles
// Ports:
//   clk, rst (async, active low), enable (edge reference advances only when 1)
//   d     asynchronous input
//   rise  synchronized 0->1 seen since last enable cycle (held until consumed)
//   fall  synchronized 1->0 seen since last enable cycle (held until consumed)
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  logic q;
  assign q = sync[SYNC_STAGES-1];
  // prev only follows q on enable cycles, so an edge stays visible until an enable cycle acts on it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {SYNC_STAGES{INIT}};
      prev <= INIT;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      if (enable) prev <= q;
    end
  end
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 MSB-first responder returning a CPU-preloaded word per received word
// Ports:
//   clk, rst (async, active low), enable (clock enable for all non-synchronizer state)
//   wide     1: 32-bit words, 0: 8-bit words (sampled at word start)
//   txdata   word to return, txload strobe writes it to txbuf
//   rxdone   read strobe, clears rxrdy and ovr
//   rxdata   last complete word (zero-extended in 8-bit mode), rxrdy unread flag
//   txfull   txbuf loaded and not yet consumed, ovr word completed while rxrdy set
//   SCLK, MOSI, SSn  asynchronous host inputs
//   MISO, MISO_oe    data to host and its tri-state enable
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] IDLE_FILL   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wide,
  input  logic [31:0] txdata,
  input  logic        txload,
  input  logic        rxdone,
  output logic [31:0] rxdata,
  output logic        rxrdy,
  output logic        txfull,
  output logic        ovr,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SSn,
  output logic        MISO,
  output logic        MISO_oe
);
  state_t state_q, state_d;
  logic [5:0] len_q, len_d, bitcnt_q, bitcnt_d;
  logic [30:0] rsr_q, rsr_d, tsr_q, tsr_d;
  logic [31:0] txbuf_q, txbuf_d, rxdata_q, rxdata_d, word;
  logic txfull_q, txfull_d, rxrdy_q, rxrdy_d, ovr_q, ovr_d;
  logic miso_q, miso_d, oe_q, oe_d;
  logic sclk_rise, sclk_fall, ssn_rise, ssn_fall, mosi_s, last, is_wide;
  logic [SYNC_STAGES-1:0] mosi_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .enable(enable), .d(SCLK), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_ssn (
    .clk(clk), .rst(rst), .enable(enable), .d(SSn), .rise(ssn_rise), .fall(ssn_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync <= '0;
    else mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign word    = txfull_q ? txbuf_q : IDLE_FILL;
  assign is_wide = len_q == 6'(WORD32);
  assign last    = bitcnt_q == len_q - 6'd1;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    bitcnt_d = bitcnt_q;
    rsr_d    = rsr_q;
    tsr_d    = tsr_q;
    txbuf_d  = txbuf_q;
    rxdata_d = rxdata_q;
    txfull_d = txfull_q;
    rxrdy_d  = rxrdy_q & ~rxdone;
    ovr_d    = ovr_q & ~rxdone;
    miso_d   = miso_q;
    oe_d     = oe_q;
    if (ssn_rise) begin
      state_d = IDLE;
      miso_d  = 1'b1;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ssn_fall) begin
          state_d = LOAD;
          oe_d    = 1'b1;
        end
        // MSB goes straight onto MISO; tsr keeps the remaining bits
        LOAD: begin
          state_d  = SHIFT;
          len_d    = wide ? 6'(WORD32) : 6'(WORD8);
          tsr_d    = word[30:0];
          txfull_d = 1'b0;
          bitcnt_d = '0;
          miso_d   = wide ? word[31] : word[7];
        end
        SHIFT: if (sclk_rise) begin
          rsr_d    = {rsr_q[29:0], mosi_s};
          bitcnt_d = bitcnt_q + 6'd1;
          if (last) begin
            state_d  = LOAD;
            rxdata_d = is_wide ? {rsr_q, mosi_s} : {24'd0, rsr_q[6:0], mosi_s};
            rxrdy_d  = 1'b1;
            ovr_d    = rxdone ? ovr_q : ovr_q | rxrdy_q;
          end
        // the fall that trails the previous word's last bit must not disturb the freshly loaded MSB
        end else if (sclk_fall && bitcnt_q != '0) begin
          tsr_d  = {tsr_q[29:0], 1'b0};
          miso_d = is_wide ? tsr_q[30] : tsr_q[6];
        end
        default: state_d = IDLE;
      endcase
    end
    if (txload) begin
      txbuf_d  = txdata;
      txfull_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      len_q    <= 6'(WORD8);
      bitcnt_q <= '0;
      rsr_q    <= '0;
      tsr_q    <= '0;
      txbuf_q  <= '0;
      rxdata_q <= '0;
      txfull_q <= 1'b0;
      rxrdy_q  <= 1'b0;
      ovr_q    <= 1'b0;
      miso_q   <= 1'b1;
      oe_q     <= 1'b0;
    end else if (enable) begin
      state_q  <= state_d;
      len_q    <= len_d;
      bitcnt_q <= bitcnt_d;
      rsr_q    <= rsr_d;
      tsr_q    <= tsr_d;
      txbuf_q  <= txbuf_d;
      rxdata_q <= rxdata_d;
      txfull_q <= txfull_d;
      rxrdy_q  <= rxrdy_d;
      ovr_q    <= ovr_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
    end
  end

  assign rxdata  = rxdata_q;
  assign rxrdy   = rxrdy_q;
  assign txfull  = txfull_q;
  assign ovr     = ovr_q;
  assign MISO    = miso_q;
  assign MISO_oe = oe_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized host-level stimulus with a scoreboard for received words
module tb_spi_slave;
  localparam logic [31:0] FILL = 32'hFFFF_FFFF;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, wide = 1'b0, txload = 1'b0, rxdone = 1'b0;
  logic SCLK = 1'b0, MOSI = 1'b0, SSn = 1'b1;
  logic [31:0] txdata = '0, rxdata;
  logic rxrdy, txfull, ovr, MISO, MISO_oe;
  int checks = 0, errors = 0, en_div = 1, en_cnt = 0;
  logic [31:0] exp_rx[$];
  logic m_txfull = 1'b0;
  logic [31:0] m_txbuf = '0, m_next = FILL;
  logic [31:0] got;
  logic [31:0] w6[3] = '{32'h0F1E_2D3C, 32'h89AB_CDEF, 32'h55AA_33CC};
  logic [31:0] rec_m[2][3], rec_r[2][3];
  logic prev_rdy = 1'b0;
  logic [31:0] prev_rx = '0;

  spi_slave #(.SYNC_STAGES(2), .IDLE_FILL(FILL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wide(wide), .txdata(txdata), .txload(txload),
    .rxdone(rxdone), .rxdata(rxdata), .rxrdy(rxrdy), .txfull(txfull), .ovr(ovr),
    .SCLK(SCLK), .MOSI(MOSI), .SSn(SSn), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    en_cnt = (en_cnt + 1) % en_div;
    enable = (en_cnt == 0);
  end

  task automatic chk32(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, g, e);
    end
  endtask

  task automatic chk1(input string name, input logic g, input logic e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, g, e);
    end
  endtask

  function automatic logic [31:0] mask(input logic [31:0] d, input logic w);
    return w ? d : {24'd0, d[7:0]};
  endfunction

  // every word start (frame start or end of a word inside a frame) takes the tx word
  task automatic consume();
    m_next = m_txfull ? m_txbuf : FILL;
    m_txfull = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_txload(input logic [31:0] d);
    @(negedge clk);
    txdata = d;
    txload = 1'b1;
    do @(posedge clk); while (!enable);
    @(negedge clk);
    txload = 1'b0;
    m_txbuf = d;
    m_txfull = 1'b1;
  endtask

  task automatic do_rxdone();
    @(negedge clk);
    rxdone = 1'b1;
    do @(posedge clk); while (!enable);
    @(negedge clk);
    rxdone = 1'b0;
  endtask

  task automatic begin_frame();
    SSn = 1'b0;
    wait_clk(8 * en_div);
    consume();
    chk1("oe_in_frame", MISO_oe, 1'b1);
  endtask

  task automatic end_frame();
    SCLK = 1'b0;
    wait_clk(4 * en_div);
    SSn = 1'b1;
    wait_clk(8 * en_div);
    chk1("oe_after_frame", MISO_oe, 1'b0);
    chk1("miso_idle", MISO, 1'b1);
  endtask

  task automatic clock_bits(input logic [31:0] d, input int n, input int nb, output logic [31:0] g);
    g = '0;
    for (int i = n - 1; i >= n - nb; i--) begin
      SCLK = 1'b0;
      MOSI = d[i];
      wait_clk(4 * en_div);
      g = {g[30:0], MISO};
      SCLK = 1'b1;
      wait_clk(4 * en_div);
    end
  endtask

  task automatic send_word(input logic [31:0] d, output logic [31:0] g);
    int n;
    logic [31:0] e;
    n = wide ? 32 : 8;
    e = mask(m_next, wide);
    exp_rx.push_back(mask(d, wide));
    clock_bits(d, n, n, g);
    chk32("miso_word", g, e);
    consume();
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!rst) begin
      prev_rdy = 1'b0;
      prev_rx = '0;
    end else begin
      if (rxrdy && (!prev_rdy || rxdata != prev_rx)) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected got %h expected none", rxdata);
        end else begin
          e = exp_rx.pop_front();
          chk32("rxdata", rxdata, e);
        end
      end
      prev_rdy = rxrdy;
      prev_rx = rxdata;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(3);
    chk32("rst_rxdata", rxdata, 32'd0);
    chk1("rst_rxrdy", rxrdy, 1'b0);
    chk1("rst_txfull", txfull, 1'b0);
    chk1("rst_ovr", ovr, 1'b0);
    chk1("rst_miso", MISO, 1'b1);
    chk1("rst_oe", MISO_oe, 1'b0);
    rst = 1'b1;
    wait_clk(4);
    // 32-bit word with preloaded reply
    wide = 1'b1;
    do_txload(32'hA5C3_0F81);
    chk1("txfull_loaded", txfull, 1'b1);
    begin_frame();
    send_word(32'h1234_5678, got);
    end_frame();
    chk1("t1_rxrdy", rxrdy, 1'b1);
    chk1("t1_txfull", txfull, 1'b0);
    do_rxdone();
    chk1("t1_rxdone", rxrdy, 1'b0);
    // 8-bit word, nothing loaded -> idle fill
    wide = 1'b0;
    begin_frame();
    send_word(32'h3C, got);
    end_frame();
    chk32("t2_rxdata", rxdata, 32'h0000_003C);
    do_rxdone();
    // overwrite txbuf, then two words in one frame with no read in between
    do_txload(32'h77);
    do_txload(32'h99);
    begin_frame();
    send_word(32'h11, got);
    send_word(32'h22, got);
    end_frame();
    chk32("t3_rxdata", rxdata, 32'h22);
    chk1("t3_ovr", ovr, 1'b1);
    chk1("t3_rxrdy", rxrdy, 1'b1);
    do_rxdone();
    chk1("t3_rxrdy_clr", rxrdy, 1'b0);
    chk1("t3_ovr_clr", ovr, 1'b0);
    // abort after 5 bits: partial word and its tx word are lost
    do_txload(32'hC4);
    begin_frame();
    clock_bits(32'hAB, 8, 5, got);
    end_frame();
    chk1("t4_rxrdy", rxrdy, 1'b0);
    chk1("t4_txfull", txfull, 1'b0);
    begin_frame();
    send_word(32'h5A, got);
    end_frame();
    chk32("t4_rxdata", rxdata, 32'h5A);
    do_rxdone();
    // reset in the middle of a 32-bit word
    wide = 1'b1;
    do_txload(32'h1357_9BDF);
    begin_frame();
    clock_bits(32'hF00D_F00D, 32, 10, got);
    rst = 1'b0;
    #1;
    chk32("mid_rst_rxdata", rxdata, 32'd0);
    chk1("mid_rst_rxrdy", rxrdy, 1'b0);
    chk1("mid_rst_txfull", txfull, 1'b0);
    chk1("mid_rst_ovr", ovr, 1'b0);
    chk1("mid_rst_miso", MISO, 1'b1);
    chk1("mid_rst_oe", MISO_oe, 1'b0);
    SCLK = 1'b0;
    SSn = 1'b1;
    MOSI = 1'b0;
    m_txfull = 1'b0;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(5);
    do_txload(32'hCAFE_BABE);
    begin_frame();
    send_word(32'hDEAD_BEEF, got);
    end_frame();
    do_rxdone();
    // same traffic at full enable rate and at 1-in-3
    for (int r = 0; r < 2; r++) begin
      en_div = r ? 3 : 1;
      wait_clk(10);
      do_txload(32'h6B8D_1E20);
      begin_frame();
      for (int k = 0; k < 3; k++) begin
        send_word(w6[k], got);
        rec_m[r][k] = got;
        rec_r[r][k] = rxdata;
        do_rxdone();
      end
      end_frame();
    end
    for (int k = 0; k < 3; k++) begin
      chk32("div_miso", rec_m[1][k], rec_m[0][k]);
      chk32("div_rxdata", rec_r[1][k], rec_r[0][k]);
    end
    // randomized frames
    for (int f = 0; f < 10; f++) begin
      int nw;
      en_div = $urandom_range(1, 3);
      wait_clk(10);
      wide = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_txload($urandom);
      begin_frame();
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        send_word($urandom, got);
        do_rxdone();
      end
      end_frame();
      chk1("rand_txfull", txfull, m_txfull);
      chk1("rand_ovr", ovr, 1'b0);
    end
    wait_clk(20);
    chk32("rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
